// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready handshakes on both sides.
// Single-cycle ops have one cycle of latency; MUL is an iterative shift-add over WIDTH cycles.
module alu_pipe #(
  parameter int WIDTH  = 16,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alu_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             is_true,
  output logic             zero,
  output logic             overflow,
  output logic             busy
);

  localparam int               CW       = $clog2(WIDTH);
  localparam int               MSB      = WIDTH - 1;
  localparam logic [WIDTH-1:0] WIDTH_V  = WIDTH[WIDTH-1:0];
  localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t             state_q;
  logic               out_valid_q, is_true_q, zero_q, ovf_q;
  logic [WIDTH-1:0]   result_q;
  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] mcand_q, acc_q;
  logic [WIDTH-1:0]   mplier_q;
  logic               neg_q;

  logic               accept, is_mul, lt, eq, sh_big;
  logic [CW-1:0]      sh_amt;
  logic [WIDTH-1:0]   sum, diff, a_abs, b_abs;
  logic [WIDTH-1:0]   result_d;
  logic               is_true_d, ovf_d;
  logic [2*WIDTH-1:0] acc_d, prod_d;
  logic [WIDTH:0]     prod_hi;
  logic               mul_ovf;

  assign in_ready = (state_q == S_IDLE) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign is_mul   = MUL_EN && (alu_op == 4'd13);

  assign sum    = a + b;
  assign diff   = a - b;
  assign lt     = $signed(a) < $signed(b);
  assign eq     = (a == b);
  assign sh_big = (b >= WIDTH_V);
  assign sh_amt = b[CW-1:0];
  assign a_abs  = a[MSB] ? -a : a;
  assign b_abs  = b[MSB] ? -b : b;

  always_comb begin
    result_d  = sum;
    is_true_d = 1'b1;
    ovf_d     = 1'b0;
    case (alu_op)
      4'd1: begin
        result_d = diff;
        ovf_d    = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
      end
      4'd2:  result_d = a | b;
      4'd3:  result_d = a & b;
      4'd4:  result_d = a ^ b;
      4'd5:  result_d = sh_big ? '0 : (a << sh_amt);
      4'd6:  result_d = sh_big ? '0 : (a >> sh_amt);
      4'd14: result_d = sh_big ? {WIDTH{a[MSB]}} : WIDTH'($signed(a) >>> sh_amt);
      4'd7:  is_true_d = eq;
      4'd8:  is_true_d = !eq;
      4'd9:  is_true_d = lt;
      4'd10: is_true_d = !lt;
      4'd11: is_true_d = lt || eq;
      4'd12: is_true_d = !(lt || eq);
      // 0, 15 and a non-iterative 13 are all ADD
      default: ovf_d = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
    endcase
  end

  // Last shift-add step folds straight into the signed product
  assign acc_d   = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
  assign prod_d  = neg_q ? -acc_d : acc_d;
  assign prod_hi = prod_d[2*WIDTH-1:WIDTH-1];
  assign mul_ovf = !((&prod_hi) || !(|prod_hi));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      is_true_q   <= 1'b0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      cnt_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      neg_q       <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            if (is_mul) begin
              state_q     <= S_MUL;
              out_valid_q <= 1'b0;
              mcand_q     <= {{WIDTH{1'b0}}, a_abs};
              mplier_q    <= b_abs;
              acc_q       <= '0;
              neg_q       <= a[MSB] ^ b[MSB];
              cnt_q       <= '0;
            end else begin
              out_valid_q <= 1'b1;
              result_q    <= result_d;
              is_true_q   <= is_true_d;
              zero_q      <= (result_d == '0);
              ovf_q       <= ovf_d;
            end
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
          end
        end
        S_MUL: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + CW'(1);
          if (cnt_q == CNT_LAST) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b1;
            result_q    <= prod_d[WIDTH-1:0];
            is_true_q   <= 1'b1;
            zero_q      <= (prod_d[WIDTH-1:0] == '0);
            ovf_q       <= mul_ovf;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign is_true   = is_true_q;
  assign zero      = zero_q;
  assign overflow  = ovf_q;
  assign busy      = (state_q == S_MUL);

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: directed corner cases plus random ops against an arithmetic reference model.
// A second instance with MUL_EN=0 covers the ADD decode of op 13.
module tb_alu_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] a = '0, b = '0;
  logic [3:0]  alu_op = '0;

  logic        in_valid = 1'b0, out_ready = 1'b1;
  logic        in_ready, out_valid, is_true, zero, overflow, busy;
  logic [15:0] result;

  logic        in_valid1 = 1'b0, out_ready1 = 1'b1;
  logic        in_ready1, out_valid1, is_true1, zero1, overflow1, busy1;
  logic [15:0] result1;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(16), .MUL_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .alu_op(alu_op), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .is_true(is_true), .zero(zero), .overflow(overflow), .busy(busy)
  );

  alu_pipe #(.WIDTH(16), .MUL_EN(1'b0)) dut_nomul (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a), .b(b), .alu_op(alu_op), .out_valid(out_valid1), .out_ready(out_ready1),
    .result(result1), .is_true(is_true1), .zero(zero1), .overflow(overflow1), .busy(busy1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Reference: plain signed/unsigned integer arithmetic, results taken mod 2^16
  function automatic void model(input logic [3:0] op, input logic [15:0] ia, input logic [15:0] ib,
                                input bit mul_en, output logic [15:0] r, output logic t, output logic v);
    longint sa, sb, x, p;
    sa = longint'($signed(ia));
    sb = longint'($signed(ib));
    t = 1'b1;
    v = 1'b0;
    x = 0;
    case (op)
      4'd1: begin x = sa - sb; v = (x > 32767) || (x < -32768); end
      4'd2: x = longint'(ia | ib);
      4'd3: x = longint'(ia & ib);
      4'd4: x = longint'(ia ^ ib);
      4'd5: x = (ib >= 16) ? 0 : longint'(ia) * (longint'(1) << ib);
      4'd6: x = (ib >= 16) ? 0 : longint'(ia) / (longint'(1) << ib);
      4'd14: begin
        if (ib >= 16) x = (sa < 0) ? -1 : 0;
        else begin
          p = longint'(1) << ib;
          x = (sa >= 0) ? sa / p : -((-sa + p - 1) / p);
        end
      end
      4'd7, 4'd8, 4'd9, 4'd10, 4'd11, 4'd12: begin
        x = sa + sb;
        case (op)
          4'd7:    t = (sa == sb);
          4'd8:    t = (sa != sb);
          4'd9:    t = (sa < sb);
          4'd10:   t = (sa >= sb);
          4'd11:   t = (sa <= sb);
          default: t = (sa > sb);
        endcase
      end
      4'd13: begin
        x = mul_en ? sa * sb : sa + sb;
        v = (x > 32767) || (x < -32768);
      end
      default: begin x = sa + sb; v = (x > 32767) || (x < -32768); end
    endcase
    r = x[15:0];
  endfunction

  task automatic check_out(input string tag, input logic [3:0] op, input logic [15:0] ia, input logic [15:0] ib);
    logic [15:0] r;
    logic t, v;
    model(op, ia, ib, 1'b1, r, t, v);
    chk({tag, ".valid"}, out_valid, 1'b1);
    chk({tag, ".result"}, result, r);
    chk({tag, ".is_true"}, is_true, t);
    chk({tag, ".zero"}, zero, (r == 16'h0));
    chk({tag, ".ovf"}, overflow, v);
  endtask

  task automatic issue(input logic [3:0] op, input logic [15:0] ia, input logic [15:0] ib);
    @(negedge clk);
    alu_op = op; a = ia; b = ib; in_valid = 1'b1;
    #1;
    chk("in_ready_before_accept", in_ready, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [3:0] op, input logic [15:0] ia, input logic [15:0] ib);
    int n;
    bit busy_bad;
    issue(op, ia, ib);
    if (op == 4'd13) begin
      chk({tag, ".mul_start_valid"}, out_valid, 1'b0);
      n = 0;
      busy_bad = 1'b0;
      while (!out_valid && n < 40) begin
        if (busy !== 1'b1 || in_ready !== 1'b0) busy_bad = 1'b1;
        @(posedge clk);
        #1;
        n++;
      end
      chk({tag, ".mul_busy"}, busy_bad, 1'b0);
      chk({tag, ".mul_latency"}, n, 16);
      chk({tag, ".busy_done"}, busy, 1'b0);
    end
    check_out(tag, op, ia, ib);
  endtask

  task automatic run_nomul(input string tag, input logic [3:0] op, input logic [15:0] ia, input logic [15:0] ib);
    logic [15:0] r;
    logic t, v;
    model(op, ia, ib, 1'b0, r, t, v);
    @(negedge clk);
    alu_op = op; a = ia; b = ib; in_valid1 = 1'b1;
    #1;
    chk({tag, ".in_ready"}, in_ready1, 1'b1);
    @(posedge clk);
    #1;
    in_valid1 = 1'b0;
    chk({tag, ".valid"}, out_valid1, 1'b1);
    chk({tag, ".busy"}, busy1, 1'b0);
    chk({tag, ".result"}, result1, r);
    chk({tag, ".is_true"}, is_true1, t);
    chk({tag, ".ovf"}, overflow1, v);
  endtask

  initial begin
    logic [3:0]  op;
    logic [15:0] ra, rb;
    bit          seen;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst.out_valid", out_valid, 1'b0);
    chk("rst.result", result, 16'h0);
    chk("rst.is_true", is_true, 1'b0);
    chk("rst.zero", zero, 1'b0);
    chk("rst.ovf", overflow, 1'b0);
    chk("rst.busy", busy, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst.in_ready", in_ready, 1'b1);

    // Reset in the middle of MUL 3*5
    issue(4'd13, 16'd3, 16'd5);
    chk("midmul.busy", busy, 1'b1);
    repeat (3) @(posedge clk);
    @(posedge clk);
    rst = 1'b1;
    #1;
    chk("midmul.out_valid", out_valid, 1'b0);
    chk("midmul.busy_clr", busy, 1'b0);
    chk("midmul.in_ready", in_ready, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 24; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    chk("midmul.no_result", seen, 1'b0);

    // Streaming single-cycle ops, one per clock
    issue(4'd0, 16'h7FFF, 16'h0001);
    chk("stream.add_result", result, 16'h8000);
    chk("stream.add_ovf", overflow, 1'b1);
    issue(4'd1, 16'd5, 16'd7);
    chk("stream.sub_result", result, 16'hFFFE);
    chk("stream.sub_ovf", overflow, 1'b0);
    issue(4'd7, 16'd3, 16'd3);
    chk("stream.eq_true", is_true, 1'b1);
    chk("stream.eq_result", result, 16'd6);
    chk("stream.valid", out_valid, 1'b1);

    // Multiplies
    run_op("mul_m3x7", 4'd13, 16'hFFFD, 16'd7);
    chk("mul_m3x7.const", result, 16'hFFEB);
    run_op("mul_minx1", 4'd13, 16'h8000, 16'hFFFF);
    chk("mul_minx1.const", result, 16'h8000);
    chk("mul_minx1.ovf", overflow, 1'b1);

    // Backpressure: hold, then consume + accept on the same edge
    issue(4'd0, 16'd10, 16'd20);
    @(negedge clk);
    out_ready = 1'b0;
    alu_op = 4'd4; a = 16'h00FF; b = 16'h0F0F; in_valid = 1'b1;
    #1;
    chk("bp.in_ready_low", in_ready, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("bp.held_result", result, 16'd30);
    chk("bp.held_valid", out_valid, 1'b1);
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    chk("bp.in_ready_high", in_ready, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("bp.xor_result", result, 16'h0FF0);
    chk("bp.valid_stays", out_valid, 1'b1);

    // Shifts
    issue(4'd5, 16'd1, 16'd15);
    chk("sll.result", result, 16'h8000);
    issue(4'd6, 16'h8000, 16'd16);
    chk("srl_big.result", result, 16'h0000);
    chk("srl_big.zero", zero, 1'b1);
    issue(4'd14, 16'h8000, 16'd3);
    chk("sra3.result", result, 16'hF000);
    issue(4'd14, 16'h8000, 16'd20);
    chk("sra_big.result", result, 16'hFFFF);

    // MUL_EN=0 instance: op 13 is ADD
    run_nomul("nomul_2p3", 4'd13, 16'd2, 16'd3);
    chk("nomul_2p3.const", result1, 16'd5);

    // Random ops against the model
    for (int i = 0; i < 160; i++) begin
      op = 4'($urandom_range(0, 15));
      ra = 16'($urandom);
      rb = 16'($urandom);
      if ((op == 4'd5 || op == 4'd6 || op == 4'd14) && ($urandom_range(0, 3) != 0))
        rb = 16'($urandom_range(0, 20));
      if (op == 4'd13 && $urandom_range(0, 1) == 1)
        rb = 16'($signed(16'($urandom_range(0, 400))) - 16'sd200);
      run_op("rand", op, ra, rb);
    end
    for (int i = 0; i < 30; i++) begin
      op = 4'($urandom_range(0, 15));
      run_nomul("rand_nomul", op, 16'($urandom), 16'($urandom_range(0, 20)));
    end

    // Idle consume: out_valid drops with no new input
    @(posedge clk);
    #1;
    chk("idle.valid_drop", out_valid, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
